// File: rtl/shr_operand_fifo_pkg.sv
// shr_operand_fifo_pkg: shared defaults and entry sizing for the shift-right operand FIFO
package shr_operand_fifo_pkg;
    localparam int DEF_DATAWIDTH = 2;
    localparam int DEF_DEPTH = 4;
    function automatic int entry_w(input int dw);
        return 2 * dw + 1;
    endfunction
endpackage

// File: rtl/shr_fifo_mem.sv
// shr_fifo_mem: DEPTH x WIDTH register array, one sync write port, one async read port, no storage reset
module shr_fifo_mem
    import shr_operand_fifo_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int WIDTH = entry_w(DEF_DATAWIDTH),
    parameter int PTRW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTRW-1:0]  waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PTRW-1:0]  raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];
    // storage write; contents are meaningless until written, the top masks them via count
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end
    assign rdata = mem[raddr];
endmodule

// File: rtl/shr_operand_fifo.sv
// shr_operand_fifo: circular operand FIFO feeding the shift-right unit with a precomputed zero-result flag
module shr_operand_fifo
    import shr_operand_fifo_pkg::*;
#(
    parameter int DATAWIDTH = DEF_DATAWIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATAWIDTH-1:0]       in_a,
    input  logic [DATAWIDTH-1:0]       in_sh_amt,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATAWIDTH-1:0]       a,
    output logic [DATAWIDTH-1:0]       sh_amt,
    output logic                       out_zero,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PTRW = $clog2(DEPTH);
    localparam int ENTRYW = entry_w(DATAWIDTH);
    localparam int CW = PTRW + 1;
    logic [PTRW-1:0] wr_ptr, rd_ptr;
    logic [ENTRYW-1:0] wdata, rdata;
    logic push, pop, zero_flag;
    assign in_ready = count != CW'(DEPTH);
    assign out_valid = count != '0;
    assign push = in_valid & in_ready;
    assign pop = out_valid & out_ready;
    assign zero_flag = (in_sh_amt >= DATAWIDTH'(DATAWIDTH)) | (in_a == '0);
    assign wdata = {zero_flag, in_sh_amt, in_a};
    assign a = out_valid ? rdata[DATAWIDTH-1:0] : '0;
    assign sh_amt = out_valid ? rdata[2*DATAWIDTH-1:DATAWIDTH] : '0;
    assign out_zero = out_valid & rdata[ENTRYW-1];
    shr_fifo_mem #(.DEPTH(DEPTH), .WIDTH(ENTRYW), .PTRW(PTRW)) u_mem (
        .clk(Clk),
        .we(push),
        .waddr(wr_ptr),
        .wdata(wdata),
        .raddr(rd_ptr),
        .rdata(rdata)
    );
    // pointers wrap naturally at DEPTH (power of two); full/empty come from count alone
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_shr_operand_fifo.sv
// tb_shr_operand_fifo: directed scenario tests for the shift-right operand FIFO
module tb_shr_operand_fifo;
    logic Clk = 0, Rst = 1, in_valid = 0, out_ready = 0;
    logic [7:0] in_a = 0, in_sh_amt = 0;
    logic in_ready, out_valid, out_zero;
    logic [7:0] a, sh_amt;
    logic [2:0] count;
    int vectors = 0, miscompares = 0;

    shr_operand_fifo #(.DATAWIDTH(8), .DEPTH(4)) dut (
        .Clk(Clk), .Rst(Rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_sh_amt(in_sh_amt), .out_valid(out_valid), .out_ready(out_ready),
        .a(a), .sh_amt(sh_amt), .out_zero(out_zero), .count(count)
    );

    always #5 Clk = ~Clk;

    // {in_ready, out_valid, out_zero, count, a, sh_amt}
    function automatic logic [21:0] snap();
        return {in_ready, out_valid, out_zero, count, a, sh_amt};
    endfunction

    function automatic logic [21:0] exp_v(input logic ir, input logic ov, input logic z,
                                          input logic [2:0] c, input logic [7:0] ea, input logic [7:0] es);
        return {ir, ov, z, c, ea, es};
    endfunction

    task automatic cyc(input logic iv, input logic [7:0] ia, input logic [7:0] is, input logic ordy);
        in_valid = iv; in_a = ia; in_sh_amt = is; out_ready = ordy;
        @(posedge Clk); #1;
        in_valid = 0; out_ready = 0;
    endtask

    task automatic test_reset();
        logic [21:0] e;
        e = exp_v(1, 0, 0, 0, 8'h00, 8'h00);
        if (snap() !== e) begin miscompares++; $display("FAIL reset_held: got %h exp %h", snap(), e); end
        vectors++;
        @(posedge Clk); #1; Rst = 0;
        cyc(0, 8'h00, 8'h00, 1);
        if (snap() !== e) begin miscompares++; $display("FAIL reset_idle: got %h exp %h", snap(), e); end
        vectors++;
    endtask

    task automatic test_single();
        logic [21:0] e;
        cyc(1, 8'hF0, 8'd4, 0);
        e = exp_v(1, 1, 0, 1, 8'hF0, 8'd4);
        if (snap() !== e) begin miscompares++; $display("FAIL single_head: got %h exp %h", snap(), e); end
        vectors++;
        cyc(0, 8'h00, 8'h00, 1);
        e = exp_v(1, 0, 0, 0, 8'h00, 8'h00);
        if (snap() !== e) begin miscompares++; $display("FAIL single_pop: got %h exp %h", snap(), e); end
        vectors++;
    endtask

    task automatic test_zero_flag();
        logic [21:0] e [3];
        e[0] = exp_v(1, 1, 1, 3, 8'h80, 8'd8);
        e[1] = exp_v(1, 1, 1, 2, 8'h00, 8'd1);
        e[2] = exp_v(1, 1, 0, 1, 8'h01, 8'd7);
        cyc(1, 8'h80, 8'd8, 0);
        cyc(1, 8'h00, 8'd1, 0);
        cyc(1, 8'h01, 8'd7, 0);
        for (int i = 0; i < 3; i++) begin
            if (snap() !== e[i]) begin miscompares++; $display("FAIL zero_flag%0d: got %h exp %h", i, snap(), e[i]); end
            vectors++;
            cyc(0, 8'h00, 8'h00, 1);
        end
        if (count !== 3'd0) begin miscompares++; $display("FAIL zero_drain: got %0d exp 0", count); end
        vectors++;
    endtask

    task automatic test_fill_wrap();
        logic [7:0] ord [4];
        for (int i = 0; i < 6; i++) begin
            cyc(1, 8'h11 + 8'(i), 8'd1 + 8'(i), 0);
            if ({in_ready, count} !== {i < 3, (i < 4) ? 3'(i + 1) : 3'd4}) begin
                miscompares++; $display("FAIL fill%0d: got ready=%b count=%0d", i, in_ready, count);
            end
            vectors++;
        end
        for (int i = 0; i < 2; i++) begin
            if ({a, sh_amt} !== {8'h11 + 8'(i), 8'd1 + 8'(i)}) begin
                miscompares++; $display("FAIL fill_pop%0d: got %h%h exp %h%h", i, a, sh_amt, 8'h11 + 8'(i), 8'd1 + 8'(i));
            end
            vectors++;
            cyc(0, 8'h00, 8'h00, 1);
        end
        cyc(1, 8'h21, 8'd2, 0);
        cyc(1, 8'h22, 8'd3, 0);
        ord[0] = 8'h13; ord[1] = 8'h14; ord[2] = 8'h21; ord[3] = 8'h22;
        for (int i = 0; i < 4; i++) begin
            if ({a, count} !== {ord[i], 3'(4 - i)}) begin
                miscompares++; $display("FAIL wrap_order%0d: got a=%h count=%0d exp a=%h count=%0d", i, a, count, ord[i], 4 - i);
            end
            vectors++;
            cyc(0, 8'h00, 8'h00, 1);
        end
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL wrap_empty: got %b exp 0", out_valid); end
        vectors++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] ord [4];
        cyc(1, 8'h31, 8'd0, 0);
        cyc(1, 8'h32, 8'd0, 0);
        cyc(1, 8'h33, 8'd0, 1);
        if ({a, count} !== {8'h32, 3'd2}) begin miscompares++; $display("FAIL simul0: got a=%h count=%0d exp a=32 count=2", a, count); end
        vectors++;
        cyc(1, 8'h34, 8'd0, 1);
        if ({a, count} !== {8'h33, 3'd2}) begin miscompares++; $display("FAIL simul1: got a=%h count=%0d exp a=33 count=2", a, count); end
        vectors++;
        ord[0] = 8'h33; ord[1] = 8'h34;
        for (int i = 0; i < 2; i++) begin
            if (a !== ord[i]) begin miscompares++; $display("FAIL simul_drain%0d: got %h exp %h", i, a, ord[i]); end
            vectors++;
            cyc(0, 8'h00, 8'h00, 1);
        end
        // shift of zero with nonzero operand must not flag zero
        cyc(1, 8'h31, 8'd0, 0);
        if (out_zero !== 1'b0) begin miscompares++; $display("FAIL simul_zflag: got %b exp 0", out_zero); end
        vectors++;
        cyc(0, 8'h00, 8'h00, 1);
    endtask

    task automatic test_full_pop();
        logic [21:0] e;
        for (int i = 0; i < 4; i++) cyc(1, 8'h41 + 8'(i), 8'd0, 0);
        cyc(1, 8'h55, 8'd0, 1);
        e = exp_v(1, 1, 0, 3, 8'h42, 8'd0);
        if (snap() !== e) begin miscompares++; $display("FAIL full_pop: got %h exp %h", snap(), e); end
        vectors++;
        for (int i = 0; i < 3; i++) begin
            if (a !== 8'h42 + 8'(i)) begin miscompares++; $display("FAIL full_drain%0d: got %h exp %h", i, a, 8'h42 + 8'(i)); end
            vectors++;
            cyc(0, 8'h00, 8'h00, 1);
        end
        if (count !== 3'd0) begin miscompares++; $display("FAIL full_nopass: got %0d exp 0", count); end
        vectors++;
    endtask

    task automatic test_mid_reset();
        logic [21:0] e;
        for (int i = 0; i < 3; i++) cyc(1, 8'h51 + 8'(i), 8'd1, 0);
        if (count !== 3'd3) begin miscompares++; $display("FAIL mid_pre: got %0d exp 3", count); end
        vectors++;
        #2 Rst = 1;
        #1;
        e = exp_v(1, 0, 0, 0, 8'h00, 8'h00);
        if (snap() !== e) begin miscompares++; $display("FAIL mid_async: got %h exp %h", snap(), e); end
        vectors++;
        @(posedge Clk); #1; Rst = 0;
        cyc(0, 8'h00, 8'h00, 1);
        if (snap() !== e) begin miscompares++; $display("FAIL mid_release: got %h exp %h", snap(), e); end
        vectors++;
        cyc(1, 8'h61, 8'd2, 0);
        e = exp_v(1, 1, 0, 1, 8'h61, 8'd2);
        if (snap() !== e) begin miscompares++; $display("FAIL mid_fresh: got %h exp %h", snap(), e); end
        vectors++;
    endtask

    initial begin
        #2;
        test_reset();
        test_single();
        test_zero_flag();
        test_fill_wrap();
        test_back_to_back();
        test_full_pop();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
